// File: rtl/icache_responder.sv
// Instruction-side responder: direct-mapped, read-only line store answering fetch
// word reads in the same cycle on a hit, refilling whole 128-bit lines on a miss.
module icache_responder #(
    parameter int NUM_LINES  = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  if_memaddr,
    input  logic         if_memread,
    input  logic [1:0]   if_mem_byte_enable,
    output logic         if_mem_resp,
    output logic [15:0]  if_mem_rdata,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IW   = $clog2(NUM_LINES);
    localparam int OFFW = $clog2(LINE_BYTES);
    localparam int TW   = 16 - OFFW - IW;
    localparam int WW   = OFFW - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TW-1:0]        tag_store  [NUM_LINES];
    logic [127:0]         data_store [NUM_LINES];
    logic [15:0]          miss_addr;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_index;
    logic [WW-1:0] req_word;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic [127:0]  req_line;
    logic [6:0]    word_lsb;
    logic          hit;
    logic          miss;
    logic          fill_en;

    // Byte enables and the byte-select address bit have no effect on a word fetch.
    logic unused_inputs;
    assign unused_inputs = ^{if_mem_byte_enable, if_memaddr[0]};

    assign req_tag    = if_memaddr[15 -: TW];
    assign req_index  = if_memaddr[OFFW +: IW];
    assign req_word   = if_memaddr[1 +: WW];
    assign fill_index = miss_addr[OFFW +: IW];
    assign fill_tag   = miss_addr[15 -: TW];

    assign req_line = data_store[req_index];
    assign word_lsb = {req_word, 4'b0000};

    assign hit     = if_memread && valid[req_index] && (tag_store[req_index] == req_tag)
                     && (state == IDLE);
    assign miss    = if_memread && !hit && (state == IDLE);
    assign fill_en = (state == FETCH) && pmem_resp;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        state_next   = state;
        if_mem_resp  = 1'b0;
        if_mem_rdata = 16'h0000;
        pmem_read    = 1'b0;
        pmem_address = 16'h0000;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    if_mem_resp  = 1'b1;
                    if_mem_rdata = req_line[word_lsb +: 16];
                end else if (miss) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = miss_addr;
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Miss address is frozen for the whole fill so a redirect cannot retarget it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_addr <= 16'h0000;
        end else if (miss) begin
            miss_addr <= {if_memaddr[15:OFFW], {OFFW{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone gate their use,
    // which keeps the storage mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_store[fill_index]  <= fill_tag;
            data_store[fill_index] <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Randomized self-checking bench for icache_responder against a line-level
// reference model with a synthetic physical memory.
module tb_icache_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  if_memaddr;
    logic         if_memread;
    logic [1:0]   if_mem_byte_enable;
    logic         if_mem_resp;
    logic [15:0]  if_mem_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]  seed;
    bit           ref_valid [8];
    logic [8:0]   ref_tag   [8];
    logic [127:0] ref_data  [8];

    icache_responder #(.NUM_LINES(8), .LINE_BYTES(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .if_memaddr         (if_memaddr),
        .if_memread         (if_memread),
        .if_mem_byte_enable (if_mem_byte_enable),
        .if_mem_resp        (if_mem_resp),
        .if_mem_rdata       (if_mem_rdata),
        .pmem_address       (pmem_address),
        .pmem_read          (pmem_read),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Physical memory contents: a deterministic function of the line address.
    function automatic logic [127:0] line_data(input logic [15:0] la);
        logic [127:0] d;
        for (int w = 0; w < 8; w++) begin
            d[16*w +: 16] = (la ^ seed) + 16'(w * 16'h1357);
        end
        return d;
    endfunction

    function automatic bit m_hit(input logic [15:0] a);
        int idx = int'(a[6:4]);
        return ref_valid[idx] && (ref_tag[idx] == a[15:7]);
    endfunction

    function automatic logic [15:0] m_word(input logic [15:0] a);
        int idx = int'(a[6:4]);
        int w   = int'(a[3:1]);
        return ref_data[idx][16*w +: 16];
    endfunction

    task automatic m_fill(input logic [15:0] la);
        int idx = int'(la[6:4]);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = la[15:7];
        ref_data[idx]  = line_data(la);
    endtask

    task automatic m_clear();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic garbage_pmem();
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase with the
    // request still raised. A miss is answered n cycles after FETCH is entered.
    task automatic read_word(input logic [15:0] a, input int n);
        logic [15:0] la;
        la = {a[15:4], 4'b0000};
        if_memaddr         = a;
        if_memread         = 1'b1;
        if_mem_byte_enable = 2'($urandom);
        @(negedge clk);
        if (m_hit(a)) begin
            check("hit_resp", 32'(if_mem_resp), 32'd1);
            check("hit_data", 32'(if_mem_rdata), 32'(m_word(a)));
            check("hit_no_pmem", 32'(pmem_read), 32'd0);
            @(posedge clk); #1;
        end else begin
            check("miss_resp", 32'(if_mem_resp), 32'd0);
            check("miss_data", 32'(if_mem_rdata), 32'd0);
            check("miss_c0_pmem", 32'(pmem_read), 32'd0);
            @(posedge clk); #1;
            for (int c = 1; c <= n; c++) begin
                if (c == n) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_data(la);
                end
                @(negedge clk);
                check("fetch_pmem_read", 32'(pmem_read), 32'd1);
                check("fetch_pmem_addr", 32'(pmem_address), 32'(la));
                check("fetch_resp", 32'(if_mem_resp), 32'd0);
                @(posedge clk); #1;
            end
            garbage_pmem();
            m_fill(la);
            @(negedge clk);
            check("refill_resp", 32'(if_mem_resp), 32'd1);
            check("refill_data", 32'(if_mem_rdata), 32'(m_word(a)));
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if_memread = 1'b0;
            if_memaddr = 16'($urandom);
            @(negedge clk);
            check("idle_resp", 32'(if_mem_resp), 32'd0);
            check("idle_data", 32'(if_mem_rdata), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [15:0] a;
        seed               = 16'($urandom);
        reset              = 1'b1;
        if_memaddr         = 16'h0000;
        if_memread         = 1'b0;
        if_mem_byte_enable = 2'b00;
        garbage_pmem();
        m_clear();

        #3;
        check("rst_resp", 32'(if_mem_resp), 32'd0);
        check("rst_data", 32'(if_mem_rdata), 32'd0);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_pmem_addr", 32'(pmem_address), 32'd0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        // Cold miss: pmem_resp three cycles after pmem_read rises.
        read_word(16'h1002, 4);

        // Every word of the filled line, back to back.
        for (int i = 0; i < 8; i++) read_word(16'h1000 + 16'(2 * i), 1);
        idle(1);

        // Conflict on index 0, then the evicted line misses again.
        read_word(16'h1080, 2);
        read_word(16'h1000, 1);
        idle(1);

        // Redirect during fill: the 0x2000 fill completes, then 0x3010 is fetched.
        if_memaddr = 16'h2000;
        if_memread = 1'b1;
        @(negedge clk);
        check("redir_miss_resp", 32'(if_mem_resp), 32'd0);
        @(posedge clk); #1;
        if_memaddr = 16'h3010;
        @(negedge clk);
        check("redir_pmem_addr", 32'(pmem_address), 32'h2000);
        check("redir_pmem_read", 32'(pmem_read), 32'd1);
        @(posedge clk); #1;
        pmem_resp  = 1'b1;
        pmem_rdata = line_data(16'h2000);
        @(negedge clk);
        check("redir_hold_addr", 32'(pmem_address), 32'h2000);
        check("redir_fill_resp", 32'(if_mem_resp), 32'd0);
        @(posedge clk); #1;
        garbage_pmem();
        m_fill(16'h2000);
        read_word(16'h3010, 2);
        read_word(16'h2000, 1);
        idle(1);

        // Stray pmem response in IDLE must change nothing.
        if_memread = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = line_data(16'hFFF0);
        @(negedge clk);
        check("stray_resp", 32'(if_mem_resp), 32'd0);
        check("stray_data", 32'(if_mem_rdata), 32'd0);
        check("stray_pmem_read", 32'(pmem_read), 32'd0);
        @(posedge clk); #1;
        garbage_pmem();
        read_word(16'h3012, 1);
        read_word(16'h1004, 1);
        read_word(16'h2006, 1);
        idle(1);

        // Reset in the middle of a fill.
        if_memaddr = 16'h4000;
        if_memread = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstfill_pre_read", 32'(pmem_read), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rstfill_pmem_read", 32'(pmem_read), 32'd0);
        check("rstfill_pmem_addr", 32'(pmem_address), 32'd0);
        check("rstfill_resp", 32'(if_mem_resp), 32'd0);
        if_memread = 1'b0;
        m_clear();
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        pmem_resp  = 1'b1;
        pmem_rdata = line_data(16'h4000);
        @(negedge clk);
        check("late_resp_pmem_read", 32'(pmem_read), 32'd0);
        @(posedge clk); #1;
        garbage_pmem();
        read_word(16'h1000, 2);
        read_word(16'h4000, 1);
        read_word(16'h2000, 3);

        // Randomized traffic over a small tag set to mix hits and conflicts.
        for (int k = 0; k < 120; k++) begin
            a        = 16'($urandom);
            a[15:9]  = 7'd0;
            read_word(a, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
